// File: rtl/ppu_vga_scaler.sv
// ppu_vga_scaler
//   Bridges the PPU pixel pipeline to a 640x480@60 VGA output (800x525 total).
//   The PPU writes one 256-pixel NES scanline of 6-bit palette indices at a
//   time into a ping-pong line buffer. Each buffered line is scanned out twice
//   (two VGA lines), each pixel doubled horizontally, and the 512x480 image is
//   centred between black borders. A 64-entry palette ROM yields RGB332.
//
// Ports
//   clk           VGA pixel clock; the PPU side uses enables in this domain
//   rst           synchronous, active-high reset
//   wr_en         write wr_pix into column wr_x of the current write bank
//   wr_x          NES column (0..255)
//   wr_pix        palette index
//   wr_line_done  1-cycle pulse: current write bank is complete
//   wr_ready      current write bank is free (PPU stalls while low)
//   frame_start   1-cycle pulse at hcount==0, vcount==0
//   underflow     sticky: a line pair began with no full bank
//   hsync_n       VGA hsync, active low
//   vsync_n       VGA vsync, active low
//   vga_r/g/b     RGB332 pixel, 2 cycles behind the counters
module ppu_vga_scaler #(
  parameter int H_BORDER = 64,
  parameter int PIX_W    = 6,
  parameter int LINE_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_x,
  input  logic [PIX_W-1:0] wr_pix,
  input  logic             wr_line_done,
  output logic             wr_ready,
  output logic             frame_start,
  output logic             underflow,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic [2:0]       vga_r,
  output logic [2:0]       vga_g,
  output logic [1:0]       vga_b
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] HS_FIRST  = 10'd656;
  localparam logic [9:0] HS_LAST   = 10'd751;
  localparam logic [9:0] VS_FIRST  = 10'd490;
  localparam logic [9:0] VS_LAST   = 10'd491;
  localparam logic [9:0] WIN_LO    = 10'(H_BORDER);
  localparam logic [9:0] WIN_HI    = 10'(H_BORDER + 2 * LINE_LEN);

  typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} rd_state_e;

  logic [9:0]       hcount, vcount;
  rd_state_e        state, state_nx;
  logic [1:0]       full, full_nx;
  logic             wr_bank, rd_bank;
  logic             pair_start, line_end, accept_done;
  logic             release_bank, underflow_set;
  logic             in_window;
  logic [7:0]       nes_x;
  logic [PIX_W-1:0] line_ram [0:2*LINE_LEN-1];
  logic [PIX_W-1:0] rd_pix;
  logic             draw_d1, hs_d1, vs_d1;
  logic [7:0]       rgb;

  // Fixed palette: channels are a scrambled view of the index, never all-zero
  // for index 0 so the first colour is distinguishable from the border.
  function automatic logic [7:0] pal_rom(input logic [5:0] idx);
    return {idx[2:0], idx[5:3], idx[5:4] ^ idx[1:0]} ^ 8'hA5;
  endfunction

  assign line_end    = (hcount == H_LAST);
  assign pair_start  = (hcount == 10'd0) && (vcount < V_VISIBLE) && !vcount[0];
  assign accept_done = wr_line_done && !full[wr_bank];
  assign wr_ready    = ~full[wr_bank];
  // Counters sit at zero throughout reset; gating keeps the pulse for the
  // first cycle after release only.
  assign frame_start = !rst && (hcount == 10'd0) && (vcount == 10'd0);

  // Read-side FSM: one full bank is held for a pair of VGA lines.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_nx      = state;
    release_bank  = 1'b0;
    underflow_set = 1'b0;
    case (state)
      IDLE: begin
        if (pair_start) begin
          if (full[rd_bank]) state_nx = SHOW0;
          else               underflow_set = 1'b1;
        end
      end
      SHOW0: if (line_end) state_nx = SHOW1;
      SHOW1: begin
        if (line_end) begin
          state_nx     = IDLE;
          release_bank = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Writer sets full[wr_bank], reader clears full[rd_bank]; the writer never
  // owns a full bank, so the two indices differ whenever both fire.
  always_comb begin
    full_nx = full;
    if (accept_done)  full_nx[wr_bank] = 1'b1;
    if (release_bank) full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount    <= '0;
      vcount    <= '0;
      state     <= IDLE;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (line_end) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
      state <= state_nx;
      full  <= full_nx;
      if (accept_done)   wr_bank   <= ~wr_bank;
      if (release_bank)  rd_bank   <= ~rd_bank;
      if (underflow_set) underflow <= 1'b1;
    end
  end

  assign in_window = (state != IDLE) && (vcount < V_VISIBLE) &&
                     (hcount >= WIN_LO) && (hcount < WIN_HI);
  assign nes_x     = 8'((hcount - WIN_LO) >> 1);

  // NOTE: the line RAM has no reset; stale contents are never displayed
  // because the full flags, which are reset, gate every read.
  always_ff @(posedge clk) begin
    if (wr_en && !full[wr_bank]) line_ram[{wr_bank, wr_x}] <= wr_pix;
    rd_pix <= line_ram[{rd_bank, nes_x}];
  end

  // Stage 1 carries RAM read alongside the delayed flags; stage 2 does the
  // palette lookup, so syncs and pixels leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_d1 <= 1'b0;
      hs_d1   <= 1'b1;
      vs_d1   <= 1'b1;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      rgb     <= '0;
    end else begin
      draw_d1 <= in_window;
      hs_d1   <= !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      vs_d1   <= !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
      hsync_n <= hs_d1;
      vsync_n <= vs_d1;
      rgb     <= draw_d1 ? pal_rom(rd_pix) : 8'd0;
    end
  end

  assign vga_r = rgb[7:5];
  assign vga_g = rgb[4:2];
  assign vga_b = rgb[1:0];

endmodule

// File: tb/tb_ppu_vga_scaler.sv
// Bench for ppu_vga_scaler. A scoreboard queue receives each line the bench
// expects to be accepted; a negedge monitor pops one per line pair and checks
// every output pixel and both syncs against the 2-cycle-delayed position.
module tb_ppu_vga_scaler;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_x;
  logic [5:0] wr_pix;
  logic       wr_line_done;
  logic       wr_ready, frame_start, underflow, hsync_n, vsync_n;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic [7:0] rgb_out;

  ppu_vga_scaler dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix),
    .wr_line_done(wr_line_done), .wr_ready(wr_ready), .frame_start(frame_start),
    .underflow(underflow), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  assign rgb_out = {vga_r, vga_g, vga_b};

  always #20 clk = ~clk;

  typedef logic [256*6-1:0] line_t;

  int    checks = 0;
  int    failures = 0;
  int    fail_prints = 0;
  int    cnt = 0;
  bit    mon_en = 1'b0;
  line_t sb[$];
  line_t cur;
  bit    shown = 1'b0;
  int    mp, mh, mv;
  logic [7:0] exp_rgb;
  logic  exp_hs, exp_vs;

  // Linear position of the DUT counters since reset release.
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  function automatic logic [5:0] pat(input int id, input int x);
    logic [31:0] xv;
    xv = 32'(x);
    case (id)
      0: return xv[5:0];
      1: return 6'd63 - xv[5:0];
      2: return 6'h2A;
      3: return 6'(x * 5 + 3);
      4: return xv[7:2];
      default: return xv[5:0] ^ 6'h15;
    endcase
  endfunction

  function automatic line_t make_line(input int id);
    line_t l;
    for (int x = 0; x < 256; x++) l[x*6 +: 6] = pat(id, x);
    return l;
  endfunction

  function automatic logic [7:0] pal_exp(input logic [5:0] i);
    logic [2:0] r, g;
    logic [1:0] b;
    r = i[2:0] ^ 3'b101;
    g = i[5:3] ^ 3'b001;
    b = i[5:4] ^ i[1:0] ^ 2'b01;
    return {r, g, b};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      shown = 1'b0;
    end else if (mon_en && cnt >= 2) begin
      mp = cnt - 2;
      mh = mp % 800;
      mv = mp / 800;
      if (mh == 0 && mv < 480 && (mv % 2) == 0) begin
        if (sb.size() > 0) begin
          cur   = sb.pop_front();
          shown = 1'b1;
        end else begin
          shown = 1'b0;
          checks++;
          if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_pair v=%0d: underflow=%b required 1", mv, underflow);
          end
        end
      end
      if (mh == 0 && mv >= 480) shown = 1'b0;
      exp_rgb = 8'd0;
      if (shown && mv < 480 && mh >= 64 && mh < 576)
        exp_rgb = pal_exp(cur[((mh - 64) / 2) * 6 +: 6]);
      exp_hs = !(mh >= 656 && mh <= 751);
      exp_vs = !(mv >= 490 && mv <= 491);
      checks++;
      if (rgb_out !== exp_rgb) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL pixel v=%0d h=%0d: rgb=%h required %h", mv, mh, rgb_out, exp_rgb);
        end
      end
      checks++;
      if (hsync_n !== exp_hs || vsync_n !== exp_vs) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL sync v=%0d h=%0d: hs=%b vs=%b required hs=%b vs=%b",
                   mv, mh, hsync_n, vsync_n, exp_hs, exp_vs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int target, input string name);
    int guard = 0;
    while (cnt < target && guard < 100000) begin
      tick();
      guard++;
    end
    if (cnt != target) begin
      failures++;
      $display("FAIL wait_%s: position=%0d required %0d", name, cnt, target);
    end
  endtask

  task automatic write_line(input int id);
    for (int x = 0; x < 256; x++) begin
      wr_en  = 1'b1;
      wr_x   = 8'(x);
      wr_pix = pat(id, x);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic done_pulse();
    wr_line_done = 1'b1;
    tick();
    wr_line_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_x = '0; wr_pix = '0; wr_line_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (hsync_n !== 1'b1 || vsync_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync: hs=%b vs=%b required 1 1", hsync_n, vsync_n);
    end
    checks++;
    if (rgb_out !== 8'd0) begin
      failures++;
      $display("FAIL reset_rgb: rgb=%h required 00", rgb_out);
    end
    checks++;
    if (wr_ready !== 1'b1 || underflow !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: ready=%b underflow=%b fs=%b required 1 0 0",
               wr_ready, underflow, frame_start);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_pulse: frame_start=%b required 1", frame_start);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL frame_start_end: frame_start=%b required 0", frame_start);
    end
  endtask

  task automatic test_underflow();
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: underflow=%b required 1", underflow);
    end
  endtask

  task automatic test_hsync();
    int lows = 0;
    int first = -1;
    wait_cnt(2, "hsync");
    for (int i = 0; i < 800; i++) begin
      if (hsync_n === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
      tick();
    end
    checks++;
    if (lows != 96 || first != 656) begin
      failures++;
      $display("FAIL hsync_width: low=%0d first=%0d required 96 656", lows, first);
    end
  endtask

  task automatic test_fill();
    write_line(0);
    sb.push_back(make_line(0));
    done_pulse();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_one_ready: wr_ready=%b required 1", wr_ready);
    end
    write_line(1);
    sb.push_back(make_line(1));
    done_pulse();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_two_ready: wr_ready=%b required 0", wr_ready);
    end
    done_pulse();
    write_line(2);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_ignored_ready: wr_ready=%b required 0", wr_ready);
    end
  endtask

  task automatic test_release();
    wait_cnt(3*800 + 799, "release");
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_before: wr_ready=%b required 0", wr_ready);
    end
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_after: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_simultaneous();
    write_line(3);
    wait_cnt(5*800 + 799, "simul");
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_before: wr_ready=%b required 1", wr_ready);
    end
    sb.push_back(make_line(3));
    done_pulse();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_other_free: wr_ready=%b required 1", wr_ready);
    end
    write_line(5);
    sb.push_back(make_line(5));
    done_pulse();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_both_full: wr_ready=%b required 0", wr_ready);
    end
    wait_cnt(8*800, "simul_free");
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_freed: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_reset_mid();
    wait_cnt(98*800 + 10, "mid_fill");
    write_line(4);
    sb.push_back(make_line(4));
    done_pulse();
    write_line(0);
    sb.push_back(make_line(0));
    done_pulse();
    wait_cnt(100*800 + 300, "mid_reset");
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_ready_before: wr_ready=%b required 0", wr_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rgb_out !== 8'd0 || hsync_n !== 1'b1 || vsync_n !== 1'b1) begin
      failures++;
      $display("FAIL mid_outputs: rgb=%h hs=%b vs=%b required 00 1 1", rgb_out, hsync_n, vsync_n);
    end
    checks++;
    if (wr_ready !== 1'b1 || underflow !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_flags: ready=%b underflow=%b fs=%b required 1 0 0",
               wr_ready, underflow, frame_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL mid_counters: frame_start=%b required 1", frame_start);
    end
    tick();
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL mid_discard: underflow=%b required 1", underflow);
    end
    wait_cnt(1700, "mid_tail");
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_hsync();
    test_fill();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
